// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S DAC transmit path.
package i2s_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} tx_state_t;

  localparam int unsigned DATA_W_DEFAULT = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into i_clk and reports its rising/falling edges.
module sync_edge_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain[0] <= i_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      hist <= chain[SYNC_STAGES-1];
    end
  end

  assign o_level = chain[SYNC_STAGES-1];
  assign o_rise  = !hist && o_level;
  assign o_fall  = hist && !o_level;

endmodule

// File: rtl/i2s_dac_tx.sv
// Serializes one mono sample per LRCK frame onto both I2S slots of the WM8731 DAC input.
// BCLK and DACLRCK are codec-mastered and oversampled on the system clock.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_sample,
  input  logic              i_valid,
  output logic              o_ready,
  output logic              o_dacdat,
  output logic              o_frame_start,
  output logic              o_underflow
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic bclk_level, bclk_rise, bclk_fall;
  logic lrck_level, lrck_rise, lrck_fall;
  logic unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_bclk),
    .o_level (bclk_level),
    .o_rise  (bclk_rise),
    .o_fall  (bclk_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_daclrck),
    .o_level (lrck_level),
    .o_rise  (lrck_rise),
    .o_fall  (lrck_fall)
  );

  assign unused = ^{bclk_level, bclk_rise, lrck_level};

  logic              ready, load, frame_start, underflow;
  logic [DATA_W-1:0] hold, active, next_active;

  assign load = i_valid && ready;

  // A load coinciding with frame start bypasses the holding register.
  always_comb begin
    next_active = active;
    if (lrck_fall) begin
      if (load)        next_active = i_sample;
      else if (!ready) next_active = hold;
      else             next_active = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold        <= '0;
      active      <= '0;
      ready       <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= lrck_fall;
      underflow   <= lrck_fall && ready && !i_valid;
      active      <= next_active;
      if (lrck_fall) begin
        ready <= 1'b1;
      end else if (load) begin
        hold  <= i_sample;
        ready <= 1'b0;
      end
    end
  end

  tx_state_t         state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              dacdat, dacdat_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      dacdat <= 1'b0;
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      cnt    <= cnt_d;
      dacdat <= dacdat_d;
    end
  end

  always_comb begin
    state_d  = state;
    shreg_d  = shreg;
    cnt_d    = cnt;
    dacdat_d = dacdat;
    if (state == IDLE) begin
      dacdat_d = 1'b0;
      if (lrck_fall) begin
        shreg_d = next_active;
        cnt_d   = '0;
        state_d = DELAY;
      end
    end else if (lrck_fall || lrck_rise) begin
      // LRCK edge outranks a coincident BCLK fall: that fall carries 0, MSB follows.
      shreg_d = lrck_fall ? next_active : active;
      cnt_d   = '0;
      state_d = DELAY;
      if (bclk_fall) dacdat_d = 1'b0;
    end else if (bclk_fall) begin
      case (state)
        DELAY: begin
          dacdat_d = shreg[DATA_W-1];
          cnt_d    = CNT_W'(1);
          state_d  = SHIFT;
        end
        SHIFT: begin
          if (cnt == CNT_W'(DATA_W)) begin
            dacdat_d = 1'b0;
            state_d  = PAD;
          end else begin
            shreg_d  = shreg << 1;
            dacdat_d = shreg_d[DATA_W-1];
            cnt_d    = cnt + CNT_W'(1);
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  assign o_ready       = ready;
  assign o_dacdat      = dacdat;
  assign o_frame_start = frame_start;
  assign o_underflow   = underflow;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a codec-side driver, a frame-level reference model checked every
// cycle, and per-slot captures of what the codec would latch on each BCLK rising edge.
module tb_i2s_dac_tx;

  localparam int unsigned DW        = 16;
  localparam int unsigned HALF_BCLK = 6;
  localparam int unsigned SLOT      = 32;

  logic          clk = 1'b0, rst_n = 1'b0, bclk = 1'b1, lrck = 1'b1, valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic          ready, dacdat, frame_start, underflow;

  i2s_dac_tx #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_bclk        (bclk),
    .i_daclrck     (lrck),
    .i_sample      (sample),
    .i_valid       (valid),
    .o_ready       (ready),
    .o_dacdat      (dacdat),
    .o_frame_start (frame_start),
    .o_underflow   (underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_fail = 0;

  // reference model state
  logic          m_ready = 1'b1, m_fs = 1'b0, m_uf = 1'b0, m_dac = 1'b0, m_tx = 1'b0;
  logic [DW-1:0] m_hold = '0, m_active = '0;
  bit            bitq[$];
  logic [3:0]    lh = '0, bh = '0;
  logic          p_rst = 1'b0, p_valid = 1'b0;
  logic [DW-1:0] p_sample = '0;

  // codec driver and slot capture
  typedef struct {
    logic [DW-1:0] word;
    logic          pad;
    int unsigned   nbits;
  } slot_t;

  int unsigned ph = 1, bcnt = 0, cur_len = SLOT, left_len = SLOT, uf_count = 0;
  bit          lrck_fell = 1'b0;
  slot_t       slots[$];
  slot_t       cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic fr, rs, bf, load;
    logic s_ready, s_fs, s_uf, s_dac;
    p_rst    = rst_n;
    p_valid  = valid;
    p_sample = sample;
    @(negedge clk);
    s_ready = ready; s_fs = frame_start; s_uf = underflow; s_dac = dacdat;
    if (!p_rst) begin
      m_ready = 1'b1; m_fs = 1'b0; m_uf = 1'b0; m_dac = 1'b0; m_tx = 1'b0;
      m_hold = '0; m_active = '0; bitq.delete(); lh = '0; bh = '0;
    end else begin
      fr   = lh[3] && !lh[2];
      rs   = !lh[3] && lh[2];
      bf   = bh[3] && !bh[2];
      load = p_valid && m_ready;
      m_fs = fr;
      m_uf = 1'b0;
      if (fr) begin
        m_tx = 1'b1;
        if (load) m_active = p_sample;
        else if (!m_ready) begin m_active = m_hold; m_ready = 1'b1; end
        else begin m_active = '0; m_uf = 1'b1; end
      end else if (load) begin
        m_hold  = p_sample;
        m_ready = 1'b0;
      end
      if (m_tx && (fr || rs)) begin
        bitq.delete();
        for (int i = DW - 1; i >= 0; i--) bitq.push_back(m_active[i]);
        if (bf) m_dac = 1'b0;
      end else if (bf) begin
        m_dac = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      end
    end
    check("o_ready", 32'(s_ready), 32'(m_ready));
    check("o_frame_start", 32'(s_fs), 32'(m_fs));
    check("o_underflow", 32'(s_uf), 32'(m_uf));
    check("o_dacdat", 32'(s_dac), 32'(m_dac));
    if (s_uf) uf_count++;

    lrck_fell = 1'b0;
    if (ph == HALF_BCLK) begin
      bclk = 1'b1;
      if (cap.nbits >= 1 && cap.nbits <= DW) cap.word[DW - cap.nbits] = s_dac;
      else cap.pad = cap.pad | s_dac;
      cap.nbits++;
    end else if (ph == 0) begin
      if (bcnt == cur_len) begin
        slots.push_back(cap);
        cap.word = '0; cap.pad = 1'b0; cap.nbits = 0;
        lrck      = ~lrck;
        lrck_fell = !lrck;
        bcnt      = 0;
        cur_len   = lrck ? SLOT : left_len;
      end
      bclk = 1'b0;
      bcnt++;
    end
    ph = (ph + 1) % (2 * HALF_BCLK);
    lh = {lh[2:0], lrck};
    bh = {bh[2:0], bclk};
  endtask

  task automatic run_until_fall();
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!lrck_fell && n < 2000);
    check("frame_timeout", 32'(lrck_fell), 32'd1);
  endtask

  task automatic check_slots(input string name, input logic [DW-1:0] l, input logic [DW-1:0] r);
    slot_t s;
    check({name, "_nslots"}, 32'(slots.size() >= 2), 32'd1);
    if (slots.size() >= 2) begin
      s = slots.pop_front();
      check({name, "_left"}, 32'(s.word), 32'(l));
      check({name, "_left_pad"}, 32'(s.pad), 32'd0);
      s = slots.pop_front();
      check({name, "_right"}, 32'(s.word), 32'(r));
      check({name, "_right_pad"}, 32'(s.pad), 32'd0);
    end
  endtask

  initial begin
    slot_t s;
    cap.word = '0; cap.pad = 1'b0; cap.nbits = 0;
    repeat (4) tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_dacdat", 32'(dacdat), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 8001 loaded before the first frame
    sample = 16'h8001; valid = 1'b1; tick(); valid = 1'b0; sample = '0;
    check("a_ready_low", 32'(ready), 32'd0);
    run_until_fall(); slots.delete(); uf_count = 0;
    run_until_fall();
    check_slots("a", 16'h8001, 16'h8001);
    check("a_uf", uf_count, 0);

    // two idle frames underflow
    slots.delete(); uf_count = 0;
    run_until_fall(); run_until_fall();
    check("b_uf", uf_count, 2);
    check("b_ready", 32'(ready), 32'd1);
    check_slots("b1", 16'h0000, 16'h0000);
    check_slots("b2", 16'h0000, 16'h0000);

    // back-to-back offer: second sample dropped
    slots.delete(); repeat (50) tick();
    sample = 16'h1234; valid = 1'b1; tick();
    check("c_ready_after_first", 32'(ready), 32'd0);
    sample = 16'hABCD; tick(); valid = 1'b0;
    check("c_ready_held", 32'(ready), 32'd0);
    run_until_fall(); slots.delete(); uf_count = 0;
    run_until_fall();
    check_slots("c", 16'h1234, 16'h1234);
    check("c_uf", uf_count, 0);
    slots.delete(); uf_count = 0;
    run_until_fall();
    check_slots("c_next", 16'h0000, 16'h0000);
    check("c_next_uf", uf_count, 1);

    // load coincident with the detected LRCK fall
    slots.delete(); uf_count = 0;
    tick(); tick();
    sample = 16'h7FFF; valid = 1'b1; tick(); valid = 1'b0;
    check("d_frame_start", 32'(frame_start), 32'd1);
    check("d_ready", 32'(ready), 32'd1);
    check("d_underflow", 32'(underflow), 32'd0);
    run_until_fall();
    check_slots("d", 16'h7FFF, 16'h7FFF);
    check("d_uf_count", uf_count, 0);

    // reset mid-word
    slots.delete();
    sample = 16'hFFFF; valid = 1'b1; tick(); valid = 1'b0;
    repeat (20) tick();
    sample = 16'h1111; valid = 1'b1; tick(); valid = 1'b0;
    check("e_ready_low", 32'(ready), 32'd0);
    repeat (40) tick();
    check("e_dacdat_high", 32'(dacdat), 32'd1);
    rst_n = 1'b0; #1;
    check("e_rst_dacdat", 32'(dacdat), 32'd0);
    check("e_rst_ready", 32'(ready), 32'd1);
    tick(); tick(); rst_n = 1'b1;
    sample = 16'hC3C3; valid = 1'b1; tick(); valid = 1'b0;
    run_until_fall();
    check("e_nslots", 32'(slots.size()), 32'd2);
    if (slots.size() >= 2) begin
      s = slots.pop_front();
      s = slots.pop_front();
      check("e_right_silent", 32'(s.word), 32'd0);
      check("e_right_silent_pad", 32'(s.pad), 32'd0);
    end
    slots.delete(); uf_count = 0;
    run_until_fall();
    check_slots("e_resume", 16'hC3C3, 16'hC3C3);
    check("e_uf", uf_count, 0);

    // left slot shortened to 10 BCLKs
    repeat (50) tick();
    sample = 16'hB6D5; valid = 1'b1; tick(); valid = 1'b0;
    left_len = 10;
    run_until_fall();
    left_len = SLOT; slots.delete();
    run_until_fall();
    check("f_nslots", 32'(slots.size()), 32'd2);
    if (slots.size() >= 2) begin
      s = slots.pop_front();
      check("f_left_len", s.nbits, 10);
      check("f_left_trunc", 32'(s.word), 32'h0000B680);
      check("f_left_pad", 32'(s.pad), 32'd0);
      s = slots.pop_front();
      check("f_right", 32'(s.word), 32'h0000B6D5);
      check("f_right_pad", 32'(s.pad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

Serializes processed 16-bit audio samples from the filter datapath onto the WM8731 DAC serial input in I2S format. The codec is clock master: it supplies BCLK and DACLRCK, and this block runs entirely on the system clock, oversampling both. The block sits downstream of the IIR filter and is the output end of the same LRCK-framed sample stream the filter consumes. It accepts one mono sample per frame and transmits it on both the left and right slots.

## Interface
- DATA_W, 16: sample width; bits sent MSB-first per slot.
- SYNC_STAGES, 2: synchronizer depth for i_bclk and i_daclrck.
- i_clk  in  1  system clock; must be ≥ 8× BCLK frequency.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_bclk  in  1  codec bit clock, asynchronous to i_clk.
- i_daclrck  in  1  codec frame clock, asynchronous; low = left slot, high = right slot.
- i_sample  in  DATA_W  signed sample, two's complement.
- i_valid  in  1  i_sample valid this cycle.
- o_ready  out  1  holding register empty; a transfer occurs when i_valid && o_ready.
- o_dacdat  out  1  serial data to the codec, registered.
- o_frame_start  out  1  one-cycle pulse on each detected DACLRCK falling edge.
- o_underflow  out  1  one-cycle pulse when a frame starts with the holding register empty.

## Operation
- **Synchronization and edge detection**
  - i_bclk and i_daclrck pass through identical SYNC_STAGES flop chains, followed by one history flop.
  - bclk_fall = history && !sync; lrck_fall and lrck_rise are formed the same way.
  - Because the two chains are identical, edges that are simultaneous at the pins are also simultaneous after synchronization.
- **Holding register (1 entry)**
  - i_valid && o_ready loads i_sample and clears o_ready on the next cycle.
  - i_valid while !o_ready is ignored; the sample is dropped and no error is flagged.
- **Frame start (lrck_fall)**
  - If the holding register is full: copy it to the active register and set o_ready = 1.
  - If it is empty: load active = 0 and pulse o_underflow.
  - Pulse o_frame_start in both cases.
  - If a load (i_valid && o_ready) coincides with lrck_fall, the new sample goes to the active register. The holding register stays empty, o_ready stays 1, and there is no underflow.
- **State machine** (states IDLE, DELAY, SHIFT, PAD)
  - IDLE: o_dacdat = 0. lrck_rise is ignored. On lrck_fall, load the left-slot shift register from active and go to DELAY. Transmission is therefore always aligned to the left slot.
  - DELAY: on the next bclk_fall, drive the shift register MSB, set bit count = 1, and go to SHIFT. This is the I2S one-BCLK delay.
  - SHIFT: on each bclk_fall, shift left and drive the next bit, incrementing the count. When the count reaches DATA_W, the next bclk_fall drives 0 and the state goes to PAD.
  - PAD: drive 0 on each bclk_fall until the next LRCK edge.
  - From DELAY, SHIFT or PAD:
    - lrck_rise reloads the shift register from active (right slot) and goes to DELAY.
    - lrck_fall performs the frame-start action and goes to DELAY.
- **Priority and boundary cases**
  - An LRCK edge and bclk_fall in the same cycle: the LRCK edge wins. The shift register is reloaded, o_dacdat is driven to 0 for that cycle's fall, and the MSB goes out on the following bclk_fall.
  - LRCK edge arriving mid-word (short frame): truncate the current word immediately and reload. No error is flagged.
  - Reset asserted mid-frame: all state is cleared and the FSM returns to IDLE. The block resynchronizes on the next lrck_fall.

## Timing
- Reset values:
  - Outputs: o_dacdat = 0, o_ready = 1, o_frame_start = 0, o_underflow = 0.
  - Internal: FSM = IDLE, and the holding register, active register, shift register and bit count are all 0.
- Latency from a pin edge to its internal detection: SYNC_STAGES + 1 i_clk cycles (3 by default).
- o_dacdat updates exactly one i_clk cycle after the detected bclk_fall. It is stable before the codec samples on the BCLK rising edge, provided the i_clk ≥ 8× BCLK requirement holds.
- o_ready reasserts in the same cycle as the o_frame_start pulse.
- Sample latency: a sample accepted during frame N is transmitted in frame N+1 on both slots.
- Arithmetic: none. Bits are sent exactly as presented; no sign extension or truncation (DATA_W bits in, DATA_W bits out).

## Structure
- Package i2s_pkg:
  - typedef enum tx_state_t {IDLE, DELAY, SHIFT, PAD}.
  - localparam DATA_W_DEFAULT = 16.
  - Bit-count width: $clog2(DATA_W+1).
- Sub-module sync_edge_det (parameter SYNC_STAGES):
  - Inputs: i_clk, i_rst_n, i_async.
  - Outputs: o_level, o_rise, o_fall.
  - Instantiated twice, once for BCLK and once for DACLRCK.

## Test plan
- Load 16'h8001 before the first lrck_fall → left and right slots each read 1,0×14,1 MSB-first, starting at the 2nd BCLK fall after each LRCK edge. o_dacdat is 0 for all 16 padding BCLKs of the 32-BCLK slot.
- No i_valid ever → every frame produces an o_underflow pulse, o_dacdat stays 0, and o_ready stays 1.
- Present i_valid with 16'h1234 then 16'hABCD back-to-back in one frame → only 16'h1234 is accepted (o_ready = 0 on the 2nd) and is transmitted in the next frame. The following frame underflows.
- Assert i_valid with 16'h7FFF in the same cycle as lrck_fall → 16'h7FFF is sent in that frame, no underflow, and o_ready stays 1.
- Pulse i_rst_n low for 2 cycles mid-SHIFT → outputs return to their reset values at once. Transmission resumes only at the next left slot, with the right slot of the interrupted frame silent.
- Shortened frame (LRCK toggles after 10 BCLKs) → the word is truncated after 9 data bits and the right slot starts with a correct MSB after one BCLK delay.
